// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] ALIGN_MASK      = 2'b11;
  localparam int         DEFAULT_TIMEOUT = 16;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Backing-bus req/ack channel between the controller (master) and memory (slave).
interface dmem_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_ctrl_bus_timer.sv
// Saturating wait counter for an outstanding bus access; expired_o is high on the
// TIMEOUT-th enabled cycle after a clear and stays high until the next clear.
module bus_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] count_q;

  assign expired_o = (count_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      count_q <= '0;
    end else if (en_i && !expired_o) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Datapath-to-bus memory controller: one aligned access per instruction, Stall freezes the PC for 2..TIMEOUT+1 cycles.
// Optional DMEM_STORE_BUFFER_EN posts aligned stores without stalling; later accesses wait for the drain.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemWrite,
  input  logic            MemRead,
  input  logic [AW-1:0]   Addr,
  input  logic [DW-1:0]   WriteData,
  output logic [DW-1:0]   ReadData,
  output logic            Stall,
  output logic            AlignErr,
  output logic            BusErr,
  dmem_ctrl_if.master     bus
);

  state_e        state_q;
  logic          req_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          bus_err_q;

  logic access;
  logic aligned;
  logic start;
  logic timer_en;
  logic expired;

  assign access   = MemRead | MemWrite;
  assign aligned  = is_aligned(Addr[1:0]);
  assign start    = (state_q == IDLE) && access && aligned;
  assign AlignErr = (state_q == IDLE) && access && !aligned;
  assign timer_en = ((state_q == BUSY) || (state_q == DRAIN)) && !bus.mem_ack;

  // A misaligned access completes in its own cycle, so it must see zero data.
  assign ReadData = AlignErr ? '0 : rdata_q;
  assign BusErr   = bus_err_q;

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (start),
    .en_i      (timer_en),
    .expired_o (expired)
  );

  always_comb begin
    Stall = 1'b0;
    case (state_q)
`ifdef DMEM_STORE_BUFFER_EN
      IDLE:    Stall = start && !MemWrite;
      DRAIN:   Stall = access;
`else
      IDLE:    Stall = start;
`endif
      BUSY:    Stall = 1'b1;
      default: Stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            req_q   <= 1'b1;
            we_q    <= MemWrite;
            addr_q  <= Addr;
            wdata_q <= WriteData;
`ifdef DMEM_STORE_BUFFER_EN
            state_q <= MemWrite ? DRAIN : BUSY;
`else
            state_q <= BUSY;
`endif
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            req_q   <= 1'b0;
            state_q <= DONE;
            if (!we_q) rdata_q <= bus.mem_rdata;
          end else if (expired) begin
            req_q     <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: state_q <= IDLE;
`ifdef DMEM_STORE_BUFFER_EN
        // Posted store: the bus registers double as the one-entry buffer.
        DRAIN: begin
          if (bus.mem_ack) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end else if (expired) begin
            req_q     <= 1'b0;
            bus_err_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: inputs change at negedge, outputs sampled 1ns later.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        AlignErr;
  logic        BusErr;

  int chk = 0;
  int err = 0;

  dmem_ctrl_if #(.AW(32), .DW(32)) bus ();

  dmem_ctrl #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .AlignErr  (AlignErr),
    .BusErr    (BusErr),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; Addr = '0; WriteData = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (3) next_cycle();
    reset = 1'b0;
    settle();
    chk++; if (bus.mem_req !== 1'b0) begin err++; $display("FAIL reset_req: got %b want 0", bus.mem_req); end
    chk++; if (bus.mem_we !== 1'b0) begin err++; $display("FAIL reset_we: got %b want 0", bus.mem_we); end
    chk++; if (bus.mem_addr !== 32'h0) begin err++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr); end
    chk++; if (bus.mem_wdata !== 32'h0) begin err++; $display("FAIL reset_wdata: got %h want 0", bus.mem_wdata); end
    chk++; if (ReadData !== 32'h0) begin err++; $display("FAIL reset_rdata: got %h want 0", ReadData); end
    chk++; if ({Stall, AlignErr, BusErr} !== 3'b000) begin err++; $display("FAIL reset_flags: got %b want 000", {Stall, AlignErr, BusErr}); end
  endtask

  task automatic test_load();
    int stalls = 0;
    next_cycle(); MemRead = 1'b1; Addr = 32'h40; settle();
    stalls += int'(Stall);
    chk++; if (bus.mem_req !== 1'b0) begin err++; $display("FAIL load_req_idle: got %b want 0", bus.mem_req); end
    next_cycle(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF; settle();
    stalls += int'(Stall);
    chk++; if ({bus.mem_req, bus.mem_we} !== 2'b10) begin err++; $display("FAIL load_busy_req_we: got %b want 10", {bus.mem_req, bus.mem_we}); end
    chk++; if (bus.mem_addr !== 32'h40) begin err++; $display("FAIL load_addr: got %h want 00000040", bus.mem_addr); end
    next_cycle(); bus.mem_ack = 1'b0; MemRead = 1'b0; settle();
    chk++; if (Stall !== 1'b0) begin err++; $display("FAIL load_done_stall: got %b want 0", Stall); end
    chk++; if (ReadData !== 32'hDEADBEEF) begin err++; $display("FAIL load_done_rdata: got %h want deadbeef", ReadData); end
    chk++; if (stalls != 2) begin err++; $display("FAIL load_stall_cycles: got %0d want 2", stalls); end
    next_cycle(); settle();
    chk++; if (ReadData !== 32'hDEADBEEF || Stall !== 1'b0) begin err++; $display("FAIL load_hold: got %h/%b want deadbeef/0", ReadData, Stall); end
  endtask

`ifndef DMEM_STORE_BUFFER_EN
  task automatic test_store();
    int stalls = 0;
    next_cycle(); MemWrite = 1'b1; Addr = 32'h44; WriteData = 32'h12345678; settle();
    stalls += int'(Stall);
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      if (i == 3) begin bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0BAD0; end
      settle();
      stalls += int'(Stall);
      chk++;
      if ({bus.mem_req, bus.mem_we} !== 2'b11 || bus.mem_addr !== 32'h44 || bus.mem_wdata !== 32'h12345678) begin
        err++; $display("FAIL store_bus_hold%0d: got req/we=%b addr=%h wdata=%h want 11/00000044/12345678",
                        i, {bus.mem_req, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
      end
    end
    next_cycle(); bus.mem_ack = 1'b0; MemWrite = 1'b0; settle();
    chk++; if (stalls != 4) begin err++; $display("FAIL store_stall_cycles: got %0d want 4", stalls); end
    chk++; if ({Stall, BusErr, bus.mem_req} !== 3'b000) begin err++; $display("FAIL store_done: got stall/buserr/req=%b want 000", {Stall, BusErr, bus.mem_req}); end
    chk++; if (ReadData !== 32'hDEADBEEF) begin err++; $display("FAIL store_no_rdata: got %h want deadbeef", ReadData); end
    next_cycle(); settle();
  endtask
`endif

  task automatic test_misaligned();
    next_cycle(); MemRead = 1'b1; Addr = 32'h42; settle();
    chk++; if ({AlignErr, Stall} !== 2'b10) begin err++; $display("FAIL misalign_ld_flags: got alignerr/stall=%b want 10", {AlignErr, Stall}); end
    chk++; if (ReadData !== 32'h0) begin err++; $display("FAIL misalign_ld_rdata: got %h want 0", ReadData); end
    next_cycle(); MemRead = 1'b0; MemWrite = 1'b1; Addr = 32'h45; WriteData = 32'h55AA55AA; settle();
    chk++; if (bus.mem_req !== 1'b0) begin err++; $display("FAIL misalign_ld_req: got %b want 0", bus.mem_req); end
    chk++; if ({AlignErr, Stall} !== 2'b10) begin err++; $display("FAIL misalign_st_flags: got alignerr/stall=%b want 10", {AlignErr, Stall}); end
    next_cycle(); MemWrite = 1'b0; settle();
    chk++; if ({bus.mem_req, AlignErr} !== 2'b00) begin err++; $display("FAIL misalign_st_after: got req/alignerr=%b want 00", {bus.mem_req, AlignErr}); end
    chk++; if (ReadData !== 32'hDEADBEEF) begin err++; $display("FAIL misalign_hold: got %h want deadbeef", ReadData); end
  endtask

  task automatic test_timeout();
    int busy = 0;
    logic stall_low = 1'b0;
    next_cycle(); MemRead = 1'b1; Addr = 32'h48; settle();
    next_cycle(); settle();
    while (bus.mem_req === 1'b1 && busy < 40) begin
      busy++;
      if (Stall !== 1'b1) stall_low = 1'b1;
      next_cycle(); settle();
    end
    chk++; if (busy != 16) begin err++; $display("FAIL timeout_busy_cycles: got %0d want 16", busy); end
    chk++; if (stall_low !== 1'b0) begin err++; $display("FAIL timeout_stall: got a low Stall while busy, want high"); end
    chk++; if ({BusErr, Stall} !== 2'b10) begin err++; $display("FAIL timeout_done_flags: got buserr/stall=%b want 10", {BusErr, Stall}); end
    chk++; if (ReadData !== 32'h0) begin err++; $display("FAIL timeout_rdata: got %h want 0", ReadData); end
    MemRead = 1'b0;
    next_cycle(); settle();
    chk++; if (BusErr !== 1'b0) begin err++; $display("FAIL timeout_pulse: got %b want 0", BusErr); end
    next_cycle(); MemRead = 1'b1; Addr = 32'h4C; settle();
    chk++; if (Stall !== 1'b1) begin err++; $display("FAIL timeout_next_accept: got %b want 1", Stall); end
    next_cycle(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEF00D; settle();
    next_cycle(); bus.mem_ack = 1'b0; MemRead = 1'b0; settle();
    chk++; if (ReadData !== 32'hCAFEF00D || BusErr !== 1'b0) begin err++; $display("FAIL timeout_next_load: got %h/%b want cafef00d/0", ReadData, BusErr); end
    next_cycle(); settle();
  endtask

  task automatic test_reset_mid_busy();
    next_cycle(); MemRead = 1'b1; Addr = 32'h50; settle();
    next_cycle(); settle();
    next_cycle(); reset = 1'b1; settle();
    chk++; if (bus.mem_req !== 1'b1) begin err++; $display("FAIL rst_busy_req_before: got %b want 1", bus.mem_req); end
    next_cycle(); reset = 1'b0; MemRead = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11111111; settle();
    chk++; if ({bus.mem_req, Stall} !== 2'b00) begin err++; $display("FAIL rst_busy_after: got req/stall=%b want 00", {bus.mem_req, Stall}); end
    next_cycle(); bus.mem_ack = 1'b0; settle();
    chk++; if (ReadData !== 32'h0) begin err++; $display("FAIL rst_busy_late_ack: got %h want 0", ReadData); end
    next_cycle(); settle();
    chk++; if ({bus.mem_req, Stall, BusErr} !== 3'b000 || ReadData !== 32'h0) begin
      err++; $display("FAIL rst_busy_idle: got req/stall/buserr=%b rdata=%h want 000/0", {bus.mem_req, Stall, BusErr}, ReadData);
    end
  endtask

`ifdef DMEM_STORE_BUFFER_EN
  task automatic test_store_buffer();
    next_cycle(); MemWrite = 1'b1; Addr = 32'h80; WriteData = 32'hA5A5A5A5; settle();
    chk++; if ({Stall, bus.mem_req} !== 2'b00) begin err++; $display("FAIL sb_post: got stall/req=%b want 00", {Stall, bus.mem_req}); end
    next_cycle(); MemWrite = 1'b0; MemRead = 1'b1; Addr = 32'h84; settle();
    chk++; if ({Stall, bus.mem_req, bus.mem_we} !== 3'b111) begin err++; $display("FAIL sb_drain1: got stall/req/we=%b want 111", {Stall, bus.mem_req, bus.mem_we}); end
    chk++; if (bus.mem_addr !== 32'h80 || bus.mem_wdata !== 32'hA5A5A5A5) begin err++; $display("FAIL sb_drain_bus: got %h/%h want 00000080/a5a5a5a5", bus.mem_addr, bus.mem_wdata); end
    next_cycle(); bus.mem_ack = 1'b1; settle();
    chk++; if (Stall !== 1'b1) begin err++; $display("FAIL sb_drain2_stall: got %b want 1", Stall); end
    next_cycle(); bus.mem_ack = 1'b0; settle();
    chk++; if ({Stall, bus.mem_req} !== 2'b10) begin err++; $display("FAIL sb_after_drain: got stall/req=%b want 10", {Stall, bus.mem_req}); end
    next_cycle(); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BADF00D; settle();
    chk++; if ({bus.mem_req, bus.mem_we} !== 2'b10 || bus.mem_addr !== 32'h84) begin err++; $display("FAIL sb_load_bus: got req/we=%b addr=%h want 10/00000084", {bus.mem_req, bus.mem_we}, bus.mem_addr); end
    next_cycle(); bus.mem_ack = 1'b0; MemRead = 1'b0; settle();
    chk++; if ({Stall, BusErr} !== 2'b00 || ReadData !== 32'h0BADF00D) begin err++; $display("FAIL sb_load_done: got stall/buserr=%b rdata=%h want 00/0badf00d", {Stall, BusErr}, ReadData); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
`ifndef DMEM_STORE_BUFFER_EN
    test_store();
`endif
    test_misaligned();
    test_timeout();
    test_reset_mid_busy();
`ifdef DMEM_STORE_BUFFER_EN
    test_store_buffer();
`endif
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
